// File: rtl/secure_serdes_decryptor_core.sv
// Purpose : receive-side serial decryptor; XORs an MSB-first ciphertext stream with a rotating key and deserializes DATA_W plaintext bits.
// Latency : accepted start edge E0 -> plain_valid visible after edge E_DATA_W (one extra edge when SECURE_SERDES_DECRYPTOR_PARITY_EN is defined).
// Backpressure: the finished word is held in HOLD while plain_ready is low; no serial bits are consumed until the handshake completes.
// Optional feature: define SECURE_SERDES_DECRYPTOR_PARITY_EN to add a trailing unencrypted even-parity bit checked against the plaintext.

`default_nettype none

module secure_serdes_decryptor_core #(
    parameter int DATA_W = 8,
    parameter int KEY_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cipher_bit,
    input  logic [KEY_W-1:0]  key,
    output logic [DATA_W-1:0] plain_data,
    output logic              plain_valid,
    input  logic              plain_ready,
    output logic              busy,
    output logic              done,
    output logic              parity_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SECURE_SERDES_DECRYPTOR_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif
    localparam logic [1:0] ST_HOLD   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [KEY_W-1:0]  key_reg;
    logic [KEY_W-1:0]  key_rot;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shift_dat;
    logic              done_q;
    logic              plain_bit;
    logic              last_bit;
    logic              start_acc;
    logic              handshake;

    // A start strobe only counts while idle; busy states ignore it entirely.
    assign start_acc = (state == ST_IDLE) && start;
    assign handshake = (state == ST_HOLD) && plain_ready;

    // The key MSB always holds the key bit for the bit arriving this cycle.
    assign plain_bit = cipher_bit ^ key_reg[KEY_W-1];
    assign last_bit  = (cnt == CNT_W'(DATA_W - 1));

    // Rotate-left by one written as an index map so KEY_W=1 degenerates cleanly.
    always_comb begin
        key_rot = '0;
        for (int i = 0; i < KEY_W; i++) begin
            key_rot[(i + 1) % KEY_W] = key_reg[i];
        end
    end

    // Frame sequencing: IDLE -> SHIFT -> [PARITY] -> HOLD -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) begin
`ifdef SECURE_SERDES_DECRYPTOR_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_HOLD;
`endif
                end
            end
`ifdef SECURE_SERDES_DECRYPTOR_PARITY_EN
            ST_PARITY: begin
                state_nxt = ST_HOLD;
            end
`endif
            ST_HOLD: begin
                if (plain_ready) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: latch key on accepted start, then shift one decrypted bit per cycle.
    // The shift register doubles as the output word, so it keeps the last frame
    // until reset or the next accepted start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg   <= '0;
            cnt       <= '0;
            shift_dat <= '0;
        end else if (start_acc) begin
            key_reg   <= key;
            cnt       <= '0;
            shift_dat <= '0;
        end else if (state == ST_SHIFT) begin
            shift_dat <= {shift_dat[DATA_W-2:0], plain_bit};
            key_reg   <= key_rot;
            cnt       <= cnt + CNT_W'(1);
        end
    end

    // Completion pulse lands on the cycle after the valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= handshake;
        end
    end

`ifdef SECURE_SERDES_DECRYPTOR_PARITY_EN
    logic par_q;

    // Trailing bit is sent in clear; flag set when it breaks even parity over the plaintext.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (start_acc) begin
            par_q <= 1'b0;
        end else if (state == ST_PARITY) begin
            par_q <= cipher_bit ^ (^shift_dat);
        end
    end

    assign parity_err = par_q;
`else
    assign parity_err = 1'b0;
`endif

    assign plain_data  = shift_dat;
    assign plain_valid = (state == ST_HOLD);
    assign busy        = (state != ST_IDLE);
    assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_secure_serdes_decryptor_core.sv
`timescale 1ns/1ps

module tb_secure_serdes_decryptor_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cipher_bit;
    logic [7:0] key;
    logic       plain_ready;

    logic [7:0] pd8;
    logic       pv8, busy8, done8, perr8;
    logic [7:0] pd4;
    logic       pv4, busy4, done4, perr4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    secure_serdes_decryptor_core #(.DATA_W(8), .KEY_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cipher_bit(cipher_bit),
        .key(key), .plain_data(pd8), .plain_valid(pv8), .plain_ready(plain_ready),
        .busy(busy8), .done(done8), .parity_err(perr8)
    );

    secure_serdes_decryptor_core #(.DATA_W(8), .KEY_W(4)) dut_k4 (
        .clk(clk), .rst_n(rst_n), .start(start), .cipher_bit(cipher_bit),
        .key(key[3:0]), .plain_data(pd4), .plain_valid(pv4), .plain_ready(plain_ready),
        .busy(busy4), .done(done4), .parity_err(perr4)
    );

    // Reference: bit i of the stream (first = plaintext MSB) uses key bit kw-1-(i mod kw).
    function automatic logic [7:0] model(input logic [7:0] c, input logic [7:0] k, input int kw);
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w[7-i] = c[7-i] ^ k[kw-1-(i % kw)];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame starting at posedge+1; returns at posedge+1 of the done cycle.
    task automatic frame(input string tag, input logic [7:0] k, input logic [7:0] c,
                         input logic pb, input int stall, input bit restart3);
        logic [7:0] e8, e4;
        logic       pe8, pe4;
        e8  = model(c, k, 8);
        e4  = model(c, k, 4);
        pe8 = 1'b0;
        pe4 = 1'b0;
`ifdef SECURE_SERDES_DECRYPTOR_PARITY_EN
        pe8 = pb ^ (^e8);
        pe4 = pb ^ (^e4);
`endif
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            cipher_bit = c[7-i];
            if (restart3 && i == 3) begin
                start = 1'b1;
                key   = 8'hFF;
            end else begin
                start = 1'b0;
            end
            check({tag, "_busy_shift"}, busy8, 1);
            check({tag, "_valid_early"}, pv8, 0);
            if (i == 0) check({tag, "_done_low"}, done8, 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
`ifdef SECURE_SERDES_DECRYPTOR_PARITY_EN
        cipher_bit = pb;
        check({tag, "_valid_parity"}, pv8, 0);
        @(posedge clk); #1;
`endif
        check({tag, "_valid"}, pv8, 1);
        check({tag, "_data"}, pd8, e8);
        check({tag, "_data_k4"}, pd4, e4);
        check({tag, "_perr"}, perr8, pe8);
        check({tag, "_perr_k4"}, perr4, pe4);
        plain_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            cipher_bit = $urandom_range(0, 1);
            @(posedge clk); #1;
            check({tag, "_valid_held"}, pv8, 1);
            check({tag, "_data_held"}, pd8, e8);
            check({tag, "_done_stall"}, done8, 0);
        end
        plain_ready = 1'b1;
        @(posedge clk); #1;
        plain_ready = 1'b0;
        check({tag, "_valid_drop"}, pv8, 0);
        check({tag, "_done"}, done8, 1);
        check({tag, "_busy_idle"}, busy8, 0);
        check({tag, "_data_kept"}, pd8, e8);
        check({tag, "_done_k4"}, done4, 1);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        cipher_bit  = 1'b0;
        key         = 8'h00;
        plain_ready = 1'b0;
        #12;
        check("rst_data", pd8, 0);
        check("rst_valid", pv8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_perr", perr8, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed frames; each following frame starts in the previous done cycle.
        frame("t1", 8'hA5, 8'h3C, 1'b0, 0, 1'b0);
        check("t1_const", pd8, 8'h99);
        frame("t2", 8'hA5, 8'h3C, 1'b1, 5, 1'b0);
        frame("t3", 8'hA5, 8'h3C, 1'b0, 0, 1'b1);
        check("t3_const", pd8, 8'h99);
        frame("t5", 8'h0C, 8'h00, 1'b1, 1, 1'b0);
        check("t5_const", pd4, 8'hCC);

        // Reset mid-frame after four bits.
        @(posedge clk); #1;
        check("t4_done_clear", done8, 0);
        key   = 8'hA5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cipher_bit = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("t4_rst_data", pd8, 0);
        check("t4_rst_busy", busy8, 0);
        check("t4_rst_valid", pv8, 0);
        check("t4_rst_perr", perr8, 0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame("t4", 8'h00, 8'h5A, 1'b0, 0, 1'b0);
        check("t4_const", pd8, 8'h5A);

        // Randomized frames.
        for (int n = 0; n < 30; n++) begin
            frame("rnd", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        check("end_done_pulse", done8, 0);
        check("end_busy", busy8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
